aes_round_ctrl: RTL and testbench

//  Sequencer for the iterative AES-128 encryption core. Schedules the single shared

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_rcon_gen.sv | 27 ++
 rtl/aes_round_ctrl.sv | 117 +++++++++++
 tb/tb_aes_round_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the iterative AES-128 round controller.
// The state encoding and the rcon arithmetic are kept here so the FSM and the rcon generator use the same definitions.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSB,
        DSB,
        UPD,
        DONE
    } aes_ctrl_state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // GF(2^8) multiply-by-x with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: clears to 01 and advances by xtime once per completed round.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_step,
    output logic [7:0] o_rcon
);

    logic [7:0] r_rcon;

    // When clear and step are both requested, clear wins. This returns the sequence to round 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcon <= RCON_INIT;
        end else if (i_clr) begin
            r_rcon <= RCON_INIT;
        end else if (i_step) begin
            r_rcon <= xtime(r_rcon);
        end
    end

    assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 core.
// Each round shares one subbytes unit: the first cycle computes SubWord for the key schedule, and the second computes SubBytes for the state.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       sb_st,
    output logic       sb_sel,
    output logic       init_we,
    output logic       key_cap,
    output logic       upd_we,
    output logic       last_round,
    output logic [3:0] round_cnt,
    output logic [7:0] rcon
);

    aes_ctrl_state_t r_state;
    aes_ctrl_state_t w_nextState;
    logic [3:0]      r_roundCnt;
    logic            w_isLast;
    logic            w_abortHit;
    logic            w_rconClr;
    logic            w_rconStep;

    assign w_isLast   = (r_roundCnt == 4'(ROUNDS));
    assign w_abortHit = abort && (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // In IDLE, an abort has priority over a start.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (start && !abort) w_nextState = INIT;
            INIT:    w_nextState = KSB;
            KSB:     w_nextState = DSB;
            DSB:     w_nextState = UPD;
            UPD:     w_nextState = w_isLast ? DONE : KSB;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (abort) begin
            w_nextState = IDLE;
        end
    end

    // All strobes are Moore outputs decoded from the registered state only.
    always_comb begin
        busy       = (r_state != IDLE);
        done       = 1'b0;
        sb_st      = 1'b0;
        sb_sel     = 1'b0;
        init_we    = 1'b0;
        key_cap    = 1'b0;
        upd_we     = 1'b0;
        last_round = 1'b0;
        unique case (r_state)
            INIT: init_we = 1'b1;
            KSB: begin
                sb_st  = 1'b1;
                sb_sel = 1'b1;
            end
            DSB: begin
                sb_st   = 1'b1;
                key_cap = 1'b1;
            end
            UPD: begin
                upd_we     = 1'b1;
                last_round = w_isLast;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_roundCnt <= '0;
        end else if (w_abortHit) begin
            r_roundCnt <= '0;
        end else begin
            unique case (r_state)
                INIT:    r_roundCnt <= 4'd1;
                UPD:     if (!w_isLast) r_roundCnt <= r_roundCnt + 4'd1;
                DONE:    r_roundCnt <= '0;
                default: ;
            endcase
        end
    end

    assign w_rconClr  = (r_state == INIT) || (r_state == DONE) || w_abortHit;
    assign w_rconStep = (r_state == UPD) && !w_isLast;

    aes_rcon_gen u_rconGen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_rconClr),
        .i_step (w_rconStep),
        .o_rcon (rcon)
    );

    assign round_cnt = r_roundCnt;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl.
// A behavioural AES datapath is driven by the controller strobes so that the FIPS-197 C.1 ciphertext can be checked end to end.
module tb_aes_round_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       sb_st;
    logic       sb_sel;
    logic       init_we;
    logic       key_cap;
    logic       upd_we;
    logic       last_round;
    logic [3:0] round_cnt;
    logic [7:0] rcon;

    int testsRun;
    int testsFailed;

    localparam logic [19:0]  RESET_VEC = {8'b0000_0000, 4'd0, 8'h01};
    localparam logic [127:0] PT_C1     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C1    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [7:0]   RCON_TBL [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                               8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    aes_round_ctrl #(.ROUNDS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .sb_st      (sb_st),
        .sb_sel     (sb_sel),
        .init_we    (init_we),
        .key_cap    (key_cap),
        .upd_we     (upd_we),
        .last_round (last_round),
        .round_cnt  (round_cnt),
        .rcon       (rcon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] outVec;
    assign outVec = {busy, done, sb_st, sb_sel, init_we, key_cap, upd_we, last_round, round_cnt, rcon};

    // ---------------- behavioural AES datapath model ----------------
    logic [7:0]   sbox [256];
    logic [127:0] ptIn;
    logic [127:0] keyIn;
    logic [127:0] mState;
    logic [127:0] mKey;
    logic [127:0] mSb;
    logic [31:0]  mSubWord;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sboxCalc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) sbox[i] = sboxCalc(8'(i));
    end

    function automatic logic [127:0] subBytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [31:0] rotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [31:0] sw, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sw ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mState   <= '0;
            mKey     <= '0;
            mSb      <= '0;
            mSubWord <= '0;
        end else begin
            if (init_we) begin
                mState <= ptIn ^ keyIn;
                mKey   <= keyIn;
            end
            if (sb_st) mSb <= subBytes(sb_sel ? {4{rotWord(mKey[31:0])}} : mState);
            if (key_cap) mSubWord <= mSb[31:0];
            if (upd_we) begin
                mKey   <= nextKey(mKey, mSubWord, rcon);
                mState <= (last_round ? shiftRows(mSb) : mixColumns(shiftRows(mSb)))
                          ^ nextKey(mKey, mSubWord, rcon);
            end
        end
    end

    // ---------------- expected controller outputs ----------------
    // The argument k counts cycles since the start was accepted: 1 = INIT, 2..31 = rounds, 32 = DONE.
    function automatic logic [19:0] expVec(input int k);
        logic [7:0] strb;
        logic [3:0] rc;
        logic [7:0] rn;
        int         r;
        int         ph;
        strb = 8'b0000_0000;
        rc   = 4'd0;
        rn   = 8'h01;
        if (k == 1) begin
            strb = 8'b1000_1000;
        end else if (k >= 2 && k <= 31) begin
            r  = (k - 2) / 3 + 1;
            ph = (k - 2) % 3;
            rc = 4'(r);
            rn = RCON_TBL[r-1];
            if (ph == 0)      strb = 8'b1011_0000;
            else if (ph == 1) strb = 8'b1010_0100;
            else              strb = (r == 10) ? 8'b1000_0011 : 8'b1000_0010;
        end else if (k == 32) begin
            strb = 8'b1100_0000;
            rc   = 4'd10;
            rn   = 8'h36;
        end
        return {strb, rc, rn};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        start = s;
        abort = a;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    int doneCount;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        ptIn        = PT_C1;
        keyIn       = KEY_C1;
        rst         = 1'b1;
        applyStimulus(1'b0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            checkOutput($sformatf("idle%0d", i), 128'(outVec), 128'(RESET_VEC));
        end

        // In IDLE, abort must win over start
        applyStimulus(1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0);
        checkOutput("abortPrio", 128'(outVec), 128'(RESET_VEC));

        // Single start with busy pulses, then start held for a back-to-back run
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 66; k++) begin
            int kk;
            nextCycle();
            kk = (k > 33) ? k - 33 : k;
            checkOutput($sformatf("run k=%0d", k), 128'(outVec), 128'(expVec(kk)));
            if (kk == 32) checkOutput($sformatf("ct k=%0d", k), mState, CT_C1);
            applyStimulus((k == 5) || (k == 20) || (k == 32) || (k == 33), 1'b0);
        end

        // Reset during round 5 aborts silently
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            nextCycle();
            if (k == 1) applyStimulus(1'b0, 1'b0);
        end
        checkOutput("preRst", 128'(outVec), 128'(expVec(15)));
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rstMid", 128'(outVec), 128'(RESET_VEC));
        nextCycle();
        rst = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            if (done) doneCount++;
        end
        checkOutput("rstNoDone", 128'(doneCount), 128'(0));
        checkOutput("rstAfter", 128'(outVec), 128'(RESET_VEC));

        // Abort during KSB of round 3, then restart
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            nextCycle();
            if (k == 1) applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("abt k=%0d", k), 128'(outVec), 128'(expVec(k)));
        end
        applyStimulus(1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0);
        checkOutput("abortIdle", 128'(outVec), 128'(RESET_VEC));
        doneCount = 0;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            if (done) doneCount++;
        end
        checkOutput("abortNoDone", 128'(doneCount), 128'(0));

        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 33; k++) begin
            nextCycle();
            if (k == 1) applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("re k=%0d", k), 128'(outVec), 128'(expVec(k)));
            if (k == 32) checkOutput("reCt", mState, CT_C1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
